conv_sequencer: RTL
===================

# conv_sequencer

Control block for the 3x3 convolution datapath. It loads the kernel, then streams image columns from an upstream column source band by band. It drives the datapath's `data_in0..2`, `kernel_load`, `valid_in` and `valid_out` so that every valid window result is captured exactly once. It presents each result with row/column coordinates over a valid/ready handshake to the downstream feature-map writer.

## Interface
Parameters:
- `DATA_WIDTH`, 16: pixel and kernel word width. Matches the datapath.
- `KERNEL_SIZE`, 3: window size. Only 3 is supported.
- `IMG_WIDTH`, 32: columns per image. Must be ≥ KERNEL_SIZE.
- `IMG_HEIGHT`, 32: rows per image. Must be ≥ KERNEL_SIZE.

Ports. Clocking is fixed: one clock, asynchronous active-low reset.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to begin an image. Sampled only in IDLE.
- `kernel_reload`  in  1  sampled together with `start`. 1 loads a new kernel first; 0 reuses the held kernel.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the final result is accepted.
- `src_valid`  in  1  upstream column/kernel-row beat available.
- `src_ready`  out  1  sequencer accepts the beat.
- `src_data0`, `src_data1`, `src_data2`  in  DATA_WIDTH each  three vertically adjacent pixels, or one kernel row.
- `conv_data_in0`, `conv_data_in1`, `conv_data_in2`  out  DATA_WIDTH each  to the datapath.
- `conv_kernel_load`, `conv_valid_in`, `conv_valid_out`  out  1 each  datapath controls.
- `res_valid`  out  1  datapath `data_out` holds an unconsumed result.
- `res_ready`  in  1  downstream accepts the result.
- `res_row`  out  $clog2(IMG_HEIGHT)  output row of the held result.
- `res_col`  out  $clog2(IMG_WIDTH)  output column of the held result.

## Operation
- States: IDLE, KLOAD, STREAM, FLUSH, DRAIN.
- **IDLE.**
  - On `start`, clear `band_cnt` and `col_cnt`.
  - If `kernel_reload`=1, go to KLOAD; otherwise go to STREAM.
  - If no kernel has been loaded since reset, go to KLOAD regardless of `kernel_reload`.
- **Beat definition.** beat = `src_valid && src_ready`. Data `conv_data_inN` = `src_dataN` combinationally on a beat.
- **KLOAD.**
  - `src_ready`=1.
  - On each beat: `conv_valid_in`=1, `conv_kernel_load`=1.
  - After KERNEL_SIZE beats (`k_cnt` 0..2), go to STREAM. The first beat becomes kernel row 0.
- **STREAM.**
  - Condition cap = `col_cnt >= KERNEL_SIZE`.
  - stall = `res_valid && !res_ready`.
  - `src_ready` = !(cap && stall).
  - On a beat: `conv_valid_in`=1, `conv_valid_out`=cap, `col_cnt++`.
  - After beat number IMG_WIDTH of the band, go to FLUSH.
- **FLUSH.**
  - Captures the last window of the band. This is one synthetic beat when !stall: `conv_valid_in`=1, `conv_valid_out`=1, data=0, no source handshake.
  - Then `col_cnt`←0 and `band_cnt++`.
  - If `band_cnt` = IMG_HEIGHT−KERNEL_SIZE, go to DRAIN; otherwise go to STREAM.
- **DRAIN.** Wait until `res_valid`=0 (or is being accepted this cycle). Pulse `done` and go to IDLE.
- **Capture** is any cycle with `conv_valid_out`=1. At that edge the sequencer sets `res_valid`←1, `res_row`←`band_cnt`, `res_col`←`col_cnt`−KERNEL_SIZE. The datapath's `data_out` updates at the same edge.
- **Result handshake.**
  - `res_valid` clears on `res_ready` unless a new capture happens in the same cycle; a capture wins and keeps it at 1.
  - Capture is never issued while stall is true, so no result is overwritten.
- **Counts.**
  - Results per band: IMG_WIDTH−2.
  - Bands: IMG_HEIGHT−2.
  - Results per image: (IMG_WIDTH−2)(IMG_HEIGHT−2), which is 900 at defaults.
- **Padding.** None: valid-only convolution. The upstream source supplies bands at row stride 1.
- **Ignored inputs.** `start` is ignored while busy. `src_*` is ignored in IDLE, FLUSH and DRAIN (`src_ready`=0).

## Timing
- **Reset.** On `rst_n`=0, immediately (asynchronously):
  - state←IDLE;
  - all counters←0;
  - `kernel_valid`←0;
  - `busy`, `done`, `src_ready`, `res_valid`, `conv_*` controls←0;
  - `res_row`, `res_col`←0.
- **Reset mid-operation** aborts with no `done` pulse. The datapath contents are don't-care.
- **Output types.** `src_ready` and the `conv_*` outputs are combinational from state and inputs. `res_*`, `busy` and `done` are registered.
- **First result latency.** `res_valid` rises at the edge of the 4th image beat of a band (this beat captures window columns 0..2). With an ungated source, one result follows per cycle.
- **Band cost.** IMG_WIDTH beats + 1 FLUSH cycle, with no bubbles otherwise.
- **Backpressure.** Holding `res_ready`=0 freezes the sequencer at the next capture point. The datapath holds because `conv_valid_in`=0.
- **`src_valid` gap.** Inserts bubbles only. Nothing is lost or duplicated.

## Test plan
- **Kernel load, identity kernel.** Reset, `start`+`kernel_reload`, 3 kernel beats with centre=1. Stream an 8x5 ramp image. Expect 18 results; each equals the centre pixel; coordinates run (0,0)..(2,5) in order; `done` pulses once.
- **Reuse kernel.** Second `start` with `kernel_reload`=0 goes straight to STREAM. Expect `conv_kernel_load` never asserted, and identical results.
- **Backpressure.** Drop `res_ready` for 5 cycles at result 3. Expect `src_ready`=0 and `conv_valid_in`=0 during the stall, the result held stable, and no loss or duplication.
- **Source gaps.** Randomly deassert `src_valid` (50%) with all-ones kernel and all-ones image. Expect every result = 9 and a total of (W−2)(H−2) results.
- **Reset mid-stream.** Assert `rst_n`=0 during band 1. Expect all outputs 0 immediately, no `done`, and a clean restart on the next `start` (kernel forced reload).
- **Start while busy.** Pulse `start` in STREAM. Expect no effect on counters or results.

Source files
------------

// File: rtl/conv_sequencer.sv
// Sequencer for the 3x3 convolution datapath: loads the kernel, streams image columns
// band by band and hands each window result downstream with its row/column coordinates.
module conv_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          kernel_reload,
    output logic                          busy,
    output logic                          done,
    input  logic                          src_valid,
    output logic                          src_ready,
    input  logic [DATA_WIDTH-1:0]         src_data0,
    input  logic [DATA_WIDTH-1:0]         src_data1,
    input  logic [DATA_WIDTH-1:0]         src_data2,
    output logic [DATA_WIDTH-1:0]         conv_data_in0,
    output logic [DATA_WIDTH-1:0]         conv_data_in1,
    output logic [DATA_WIDTH-1:0]         conv_data_in2,
    output logic                          conv_kernel_load,
    output logic                          conv_valid_in,
    output logic                          conv_valid_out,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [$clog2(IMG_HEIGHT)-1:0] res_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  res_col
);

    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int CNT_W = $clog2(IMG_WIDTH + 1);
    localparam int COL_W = $clog2(IMG_WIDTH);

    localparam logic [CNT_W-1:0] CAP_START = CNT_W'(KERNEL_SIZE);
    localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] BAND_LAST = ROW_W'(IMG_HEIGHT - KERNEL_SIZE);
    localparam logic [1:0]       K_LAST    = 2'(KERNEL_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        KLOAD,
        STREAM,
        FLUSH,
        DRAIN
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [1:0]         k_cnt;
    logic [CNT_W-1:0]   col_cnt;
    logic [ROW_W-1:0]   band_cnt;
    logic               kernel_valid;
    logic               cap;
    logic               stall;
    logic               beat;
    logic               flush_fire;

    // A capture is only allowed once the window holds KERNEL_SIZE columns and the
    // previous result has been taken, so src_ready drops exactly at that point.
    assign cap        = col_cnt >= CAP_START;
    assign stall      = res_valid && !res_ready;
    assign src_ready  = (state == KLOAD) || ((state == STREAM) && !(cap && stall));
    assign beat       = src_valid && src_ready;
    assign flush_fire = (state == FLUSH) && !stall;

    always_comb begin
        next_state       = state;
        conv_valid_in    = 1'b0;
        conv_valid_out   = 1'b0;
        conv_kernel_load = 1'b0;
        conv_data_in0    = '0;
        conv_data_in1    = '0;
        conv_data_in2    = '0;
        if (beat) begin
            conv_data_in0 = src_data0;
            conv_data_in1 = src_data1;
            conv_data_in2 = src_data2;
        end
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (kernel_reload || !kernel_valid) ? KLOAD : STREAM;
                end
            end
            KLOAD: begin
                if (beat) begin
                    conv_valid_in    = 1'b1;
                    conv_kernel_load = 1'b1;
                    if (k_cnt == K_LAST) begin
                        next_state = STREAM;
                    end
                end
            end
            STREAM: begin
                if (beat) begin
                    conv_valid_in  = 1'b1;
                    conv_valid_out = cap;
                    if (col_cnt == COL_LAST) begin
                        next_state = FLUSH;
                    end
                end
            end
            // One zero-data shift pushes out the band's final window.
            FLUSH: begin
                if (flush_fire) begin
                    conv_valid_in  = 1'b1;
                    conv_valid_out = 1'b1;
                    next_state     = (band_cnt == BAND_LAST) ? DRAIN : STREAM;
                end
            end
            DRAIN: begin
                if (!res_valid || res_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
            done  <= (state == DRAIN) && (next_state == IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_cnt        <= '0;
            col_cnt      <= '0;
            band_cnt     <= '0;
            kernel_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k_cnt    <= '0;
                        col_cnt  <= '0;
                        band_cnt <= '0;
                    end
                end
                KLOAD: begin
                    if (beat) begin
                        if (k_cnt == K_LAST) begin
                            k_cnt        <= '0;
                            kernel_valid <= 1'b1;
                        end else begin
                            k_cnt <= k_cnt + 2'd1;
                        end
                    end
                end
                STREAM: begin
                    if (beat) begin
                        col_cnt <= col_cnt + CNT_W'(1);
                    end
                end
                FLUSH: begin
                    if (flush_fire) begin
                        col_cnt  <= '0;
                        band_cnt <= band_cnt + ROW_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // A capture in the same cycle as an acceptance wins, keeping res_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_row   <= '0;
            res_col   <= '0;
        end else if (conv_valid_out) begin
            res_valid <= 1'b1;
            res_row   <= band_cnt;
            res_col   <= COL_W'(col_cnt - CAP_START);
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule
